// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants
package cpu_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_t;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-word skid buffer plus instruction output mux
// Ports: clk/rst (falling edge, sync active-low), capture (load rdata),
// flush (empty the skid), boot (force NOP), rdata (memory word),
// inst (word toward IF/ID), full (skid holds a word).
module fetch_skid
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        flush,
  input  logic        boot,
  input  logic [31:0] rdata,
  output logic [31:0] inst,
  output logic        full
);
  logic [31:0] skid_inst;
  always_ff @(negedge clk) begin
    full <= rst && !flush && (capture || full);
    if (capture) skid_inst <= rdata;
  end
  assign inst = boot ? NOP_INST : full ? skid_inst : rdata;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 instruction-fetch stage feeding the IF/ID buffer
// Ports: clk (state on falling edge), rst (sync active-low), stall,
// redirect_valid/redirect_pc (EX redirect), imem_addr/imem_rdata
// (synchronous word memory), inst_o/pc_o/valid_o (toward IF/ID),
// clear_o (IF/ID flush), fetch_cnt/stall_cnt (perf counters).
// Optional counters enabled by defining FETCH_PERF_EN; otherwise tied to 0.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            inst_o,
  output logic [31:0]            pc_o,
  output logic                   valid_o,
  output logic                   clear_o,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            stall_cnt
);
  fetch_state_t state, state_nx;
  logic [31:0] fetch_pc, resp_pc, fetch_pc_nx, resp_pc_nx;
  logic advance, capture, flush, skid_full;
  // BOOT leaves unconditionally; otherwise a stall freezes the PCs
  assign advance = !redirect_valid && (state == BOOT || !stall);
  assign capture = !redirect_valid && state == RUN && stall;
  assign flush   = redirect_valid || (state == HOLD && !stall);
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    resp_pc_nx  = resp_pc;
    if (redirect_valid) begin
      state_nx    = BOOT;
      fetch_pc_nx = {redirect_pc[31:2], 2'b00};
    end else if (advance) begin
      state_nx    = RUN;
      fetch_pc_nx = fetch_pc + 32'd4;
      resp_pc_nx  = fetch_pc;
    end else if (state == RUN) begin
      state_nx = HOLD;
    end
  end
  always_ff @(negedge clk) begin
    if (!rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      resp_pc  <= resp_pc_nx;
    end
  end
  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .flush   (flush),
    .boot    (state == BOOT),
    .rdata   (imem_rdata),
    .inst    (inst_o),
    .full    (skid_full)
  );
  assign imem_addr = fetch_pc[IMEM_ADDR_W+1:2];
  assign pc_o      = resp_pc;
  assign valid_o   = state != BOOT;
  assign clear_o   = redirect_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_q, stall_q;
  always_ff @(negedge clk) begin
    if (!rst) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_q + 32'(valid_o && !stall && !redirect_valid);
      stall_q <= stall_q + 32'(stall);
    end
  end
  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule
